// File: rtl/seq_mag_comp.sv
// Multi-cycle N-bit magnitude comparator, W bits per cycle MSB chunk first, unsigned or two's-complement.
// Define SEQ_MAG_COMP_EARLY_TERM_EN to finish on the first differing chunk instead of always taking C cycles.
module seq_mag_comp #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic         e,
  output logic         g,
  output logic         l
);

  localparam int unsigned C  = N / W;
  localparam int unsigned IW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic {IDLE, CMP} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          sm_q, sm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sticky_q, sticky_d;
  logic          gt_q, gt_d;
  logic          busy_d, done_d, e_d, g_d, l_d;

  logic [W-1:0]  a_ch, b_ch;
  logic          diff, cur_g, res_diff, res_g, finish;

  // State and all outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sm_q     <= 1'b0;
      idx_q    <= '0;
      sticky_q <= 1'b0;
      gt_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      e        <= 1'b0;
      g        <= 1'b0;
      l        <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sm_q     <= sm_d;
      idx_q    <= idx_d;
      sticky_q <= sticky_d;
      gt_q     <= gt_d;
      busy     <= busy_d;
      done     <= done_d;
      e        <= e_d;
      g        <= g_d;
      l        <= l_d;
    end
  end

  // Next-state, chunk compare and result loading.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sm_d     = sm_q;
    idx_d    = idx_q;
    sticky_d = sticky_q;
    gt_d     = gt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    e_d      = e;
    g_d      = g;
    l_d      = l;

    a_ch     = W'(a_q >> (32'(idx_q) * W));
    b_ch     = W'(b_q >> (32'(idx_q) * W));
    diff     = (a_ch != b_ch);
    // Top chunk with differing sign bits in signed mode: the negative operand is smaller.
    if (sm_q && (idx_q == IW'(C - 1)) && (a_ch[W-1] != b_ch[W-1]))
      cur_g = b_ch[W-1];
    else
      cur_g = (a_ch > b_ch);
    res_diff = sticky_q | diff;
    res_g    = sticky_q ? gt_q : cur_g;
`ifdef SEQ_MAG_COMP_EARLY_TERM_EN
    finish   = (idx_q == '0) || diff;
`else
    finish   = (idx_q == '0);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          sm_d     = signed_mode;
          idx_d    = IW'(C - 1);
          sticky_d = 1'b0;
          gt_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (!sticky_q && diff) begin
          sticky_d = 1'b1;
          gt_d     = cur_g;
        end
        if (finish) begin
          e_d     = ~res_diff;
          g_d     = res_diff & res_g;
          l_d     = res_diff & ~res_g;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
